sinc_decim_rectangle_window: RTL

SINC_DECIM_RECTANGLE_WINDOW -- requirements
Module: sinc_decim_rectangle_window

---
 rtl/sinc_decim_rectangle_window.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/sinc_decim_rectangle_window.sv
// ----------------------------------------------------------------------------
// sinc_decim_rectangle_window
//
// Decimate-by-10 FIR using a 201-tap rectangular-window sinc. Input samples
// are written into a 256-entry circular buffer. Every 10th accepted sample
// (the trigger) starts a serial multiply-accumulate pass over the 201 most
// recent samples. The pass takes one tap per cycle. The accumulator is then
// shifted and saturated into the output register. That register is held
// until downstream takes it.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   in_sample is valid this cycle
//   in_ready   block accepts in_sample this cycle
//   in_sample  signed 16-bit high-rate input
//   out_valid  out_sample holds a decimated result
//   out_ready  downstream accepts out_sample
//   out_sample signed 20-bit decimated output
// ----------------------------------------------------------------------------
module sinc_decim_rectangle_window #(
    parameter int OUT_SHIFT = 9
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [15:0]  in_sample,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [19:0]  out_sample
);

    localparam int DATA_W = 16;
    localparam int COEF_W = 11;
    localparam int PROD_W = 27;
    localparam int ACC_W  = 36;
    localparam int OUT_W  = 20;

    localparam logic signed [ACC_W-1:0] OUT_MAX = 36'sd524287;
    localparam logic signed [ACC_W-1:0] OUT_MIN = -36'sd524288;

    typedef enum logic [1:0] {IDLE, MAC, HOLD} state_t;

    // Half-sinc table indexed by distance from the centre tap, 10 samples
    // per zero crossing. Distances that are multiples of 10 (other than 0)
    // sit on zero crossings and fall to the default.
    function automatic logic signed [COEF_W-1:0] coef(input logic [7:0] t);
        logic [7:0] d;
        logic signed [COEF_W-1:0] c;
        d = (t >= 8'd100) ? (t - 8'd100) : (8'd100 - t);
        case (d)
            8'd0:  c = 11'sd512;  8'd1:  c = 11'sd504;  8'd2:  c = 11'sd479;
            8'd3:  c = 11'sd439;  8'd4:  c = 11'sd387;  8'd5:  c = 11'sd326;
            8'd6:  c = 11'sd258;  8'd7:  c = 11'sd188;  8'd8:  c = 11'sd120;
            8'd9:  c = 11'sd56;
            8'd11: c = -11'sd46;  8'd12: c = -11'sd80;  8'd13: c = -11'sd101;
            8'd14: c = -11'sd111; 8'd15: c = -11'sd109; 8'd16: c = -11'sd97;
            8'd17: c = -11'sd78;  8'd18: c = -11'sd53;  8'd19: c = -11'sd27;
            8'd21: c = 11'sd24;   8'd22: c = 11'sd44;   8'd23: c = 11'sd57;
            8'd24: c = 11'sd65;   8'd25: c = 11'sd65;   8'd26: c = 11'sd60;
            8'd27: c = 11'sd49;   8'd28: c = 11'sd34;   8'd29: c = 11'sd17;
            8'd31: c = -11'sd16;  8'd32: c = -11'sd30;  8'd33: c = -11'sd40;
            8'd34: c = -11'sd46;  8'd35: c = -11'sd47;  8'd36: c = -11'sd43;
            8'd37: c = -11'sd36;  8'd38: c = -11'sd25;  8'd39: c = -11'sd13;
            8'd41: c = 11'sd12;   8'd42: c = 11'sd23;   8'd43: c = 11'sd31;
            8'd44: c = 11'sd35;   8'd45: c = 11'sd36;   8'd46: c = 11'sd34;
            8'd47: c = 11'sd28;   8'd48: c = 11'sd20;   8'd49: c = 11'sd10;
            8'd51: c = -11'sd10;  8'd52: c = -11'sd18;  8'd53: c = -11'sd25;
            8'd54: c = -11'sd29;  8'd55: c = -11'sd30;  8'd56: c = -11'sd28;
            8'd57: c = -11'sd23;  8'd58: c = -11'sd17;  8'd59: c = -11'sd9;
            8'd61: c = 11'sd8;    8'd62: c = 11'sd15;   8'd63: c = 11'sd21;
            8'd64: c = 11'sd24;   8'd65: c = 11'sd25;   8'd66: c = 11'sd23;
            8'd67: c = 11'sd20;   8'd68: c = 11'sd14;   8'd69: c = 11'sd7;
            8'd71: c = -11'sd7;   8'd72: c = -11'sd13;  8'd73: c = -11'sd18;
            8'd74: c = -11'sd21;  8'd75: c = -11'sd22;  8'd76: c = -11'sd20;
            8'd77: c = -11'sd17;  8'd78: c = -11'sd12;  8'd79: c = -11'sd6;
            8'd81: c = 11'sd6;    8'd82: c = 11'sd12;   8'd83: c = 11'sd16;
            8'd84: c = 11'sd18;   8'd85: c = 11'sd19;   8'd86: c = 11'sd18;
            8'd87: c = 11'sd15;   8'd88: c = 11'sd11;   8'd89: c = 11'sd6;
            8'd91: c = -11'sd6;   8'd92: c = -11'sd10;  8'd93: c = -11'sd14;
            8'd94: c = -11'sd16;  8'd95: c = -11'sd17;  8'd96: c = -11'sd16;
            8'd97: c = -11'sd14;  8'd98: c = -11'sd10;  8'd99: c = -11'sd5;
            default: c = '0;
        endcase
        return c;
    endfunction

    // Arithmetic shift then clamp to the 20-bit output range.
    function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] s;
        s = a >>> OUT_SHIFT;
        if (s > OUT_MAX)      s = OUT_MAX;
        else if (s < OUT_MIN) s = OUT_MIN;
        return OUT_W'(s);
    endfunction

    state_t                    state;
    logic [7:0]                wp;
    logic [3:0]                phase;
    logic [7:0]                tap;
    logic                      tap_done;
    logic [7:0]                fill;
    logic signed [DATA_W-1:0]  ring [256];

    logic signed [DATA_W-1:0]  smp_p0;
    logic signed [COEF_W-1:0]  coef_p0;
    logic                      vld_p0, last_p0;
    logic signed [PROD_W-1:0]  prod_p1;
    logic                      vld_p1, last_p1;
    logic signed [ACC_W-1:0]   acc_p2;
    logic                      last_p2;

    logic                      accept, trigger, issue;
    logic [7:0]                rd_addr;
    logic signed [PROD_W-1:0]  mul;

    // in_ready depends only on the FSM state and the phase counter. It never
    // depends on out_ready. Blocking the 10th sample in HOLD means a trigger
    // can only land in IDLE.
    assign in_ready = (state == IDLE) || ((state == HOLD) && (phase != 4'd9));
    assign accept   = in_valid && in_ready;
    assign trigger  = accept && (phase == 4'd9);
    assign issue    = (state == MAC) && !tap_done;
    // Tap 0 is the newest sample, one slot behind the write pointer.
    assign rd_addr  = wp - 8'd1 - tap;
    assign mul      = PROD_W'(smp_p0) * PROD_W'(coef_p0);

    // The buffer RAM has no reset. The fill gate keeps stale entries out.
    always_ff @(posedge clk) begin
        if (accept) ring[wp] <= in_sample;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wp         <= '0;
            phase      <= '0;
            tap        <= '0;
            tap_done   <= 1'b0;
            fill       <= '0;
            smp_p0     <= '0;
            coef_p0    <= '0;
            vld_p0     <= 1'b0;
            last_p0    <= 1'b0;
            prod_p1    <= '0;
            vld_p1     <= 1'b0;
            last_p1    <= 1'b0;
            acc_p2     <= '0;
            last_p2    <= 1'b0;
            out_valid  <= 1'b0;
            out_sample <= '0;
        end else begin
            if (accept) begin
                wp    <= wp + 8'd1;
                phase <= (phase == 4'd9) ? 4'd0 : phase + 4'd1;
                if (fill != 8'd201) fill <= fill + 8'd1;
            end

            // ---- stage p0: buffer read, coefficient lookup ----
            // A tap older than everything accepted since reset gets a zero
            // coefficient, so it adds nothing.
            smp_p0  <= ring[rd_addr];
            coef_p0 <= (issue && (tap < fill)) ? coef(tap) : '0;
            vld_p0  <= issue;
            last_p0 <= issue && (tap == 8'd200);

            // ---- stage p1: 16x11 product ----
            prod_p1 <= mul;
            vld_p1  <= vld_p0;
            last_p1 <= last_p0;

            // ---- stage p2: accumulate ----
            if (vld_p1) acc_p2 <= acc_p2 + ACC_W'(prod_p1);
            last_p2 <= last_p1;

            case (state)
                IDLE: begin
                    if (trigger) begin
                        state    <= MAC;
                        tap      <= '0;
                        tap_done <= 1'b0;
                        acc_p2   <= '0;
                    end
                end
                MAC: begin
                    if (!tap_done) begin
                        if (tap == 8'd200) tap_done <= 1'b1;
                        else               tap      <= tap + 8'd1;
                    end
                    // ---- output register: acc is final once last_p2 is set ----
                    if (last_p2) begin
                        state      <= HOLD;
                        out_valid  <= 1'b1;
                        out_sample <= sat_out(acc_p2);
                    end
                end
                HOLD: begin
                    if (out_valid && out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
